// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first, start/busy/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds input port sub).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] num_1,
    input  logic [WIDTH-1:0] num_2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    logic [WIDTH-1:0]  s_sr_q, s_sr_d;
    logic              carry_ff_q, carry_ff_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;

    logic              fa_s, fa_co;
    logic [WIDTH-1:0]  s_next;
    logic [WIDTH-1:0]  b_load;
    logic              cin_load;
    logic              load;

    // Single-bit full adder cell fed from the operand LSBs and the carry flop.
    assign fa_s   = a_sr_q[0] ^ b_sr_q[0] ^ carry_ff_q;
    assign fa_co  = (a_sr_q[0] & b_sr_q[0]) | (carry_ff_q & (a_sr_q[0] ^ b_sr_q[0]));
    assign s_next = {fa_s, s_sr_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as A + ~B + 1; carry=1 then means no borrow.
    assign b_load   = sub ? ~num_2 : num_2;
    assign cin_load = sub ? 1'b1 : c_in;
`else
    assign b_load   = num_2;
    assign cin_load = c_in;
`endif

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        s_sr_d     = s_sr_q;
        carry_ff_d = carry_ff_q;
        bit_cnt_d  = bit_cnt_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            StRun: begin
                s_sr_d     = s_next;
                carry_ff_d = fa_co;
                a_sr_d     = a_sr_q >> 1;
                b_sr_d     = b_sr_q >> 1;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                    sum_d   = s_next;
                    carry_d = fa_co;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            a_sr_d     = num_1;
            b_sr_d     = b_load;
            carry_ff_d = cin_load;
            bit_cnt_d  = '0;
            state_d    = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            s_sr_q     <= '0;
            carry_ff_q <= 1'b0;
            bit_cnt_q  <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            s_sr_q     <= s_sr_d;
            carry_ff_q <= carry_ff_d;
            bit_cnt_q  <= bit_cnt_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] num_1, num_2;
    logic         c_in;
    logic         busy, done, carry;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] prev_sum;
    logic         prev_carry;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .num_1 (num_1),
        .num_2 (num_2),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry,sum} = A + B' + cin' with B'=~B, cin'=1 when subtracting.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
        logic [W:0] bb;
        logic [W:0] cc;
        bb = sb ? {1'b0, ~b} : {1'b0, b};
        cc = sb ? (W+1)'(1) : (W+1)'(ci);
        return {1'b0, a} + bb + cc;
    endfunction

    // Runs one operation starting at a negedge; optional start glitch during RUN cycle glitch_at.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb, input int glitch_at);
        logic [W:0] r;
        r = model(a, b, ci, sb);
        start = 1'b1; num_1 = a; num_2 = b; c_in = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub = sb;
`endif
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_low"}, 32'(done), 32'd0);
            check({tag, " sum_held"}, 32'(sum), 32'(prev_sum));
            check({tag, " carry_held"}, 32'(carry), 32'(prev_carry));
            start = (k == glitch_at);
            if (k == glitch_at) begin
                num_1 = 8'hFF; num_2 = 8'hFF; c_in = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(r[W-1:0]));
        check({tag, " carry"}, 32'(carry), 32'(r[W]));
        prev_sum = r[W-1:0]; prev_carry = r[W];
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_1 = '0; num_2 = '0; c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        prev_sum = '0; prev_carry = 1'b0;
        repeat (2) @(negedge clk);
        check("rst sum", 32'(sum), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle sum", 32'(sum), 32'd0);
        check("idle carry", 32'(carry), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        do_op("35+4A", 8'h35, 8'h4A, 1'b0, 1'b0, -1);
        check("35+4A const", 32'(prev_sum), 32'h7F);
        do_op("FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, -1);
        do_op("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 1'b0, -1);

        // Start held high: second operation follows done with no idle gap.
        start = 1'b1; num_1 = 8'h10; num_2 = 8'h20; c_in = 1'b0;
        @(negedge clk);
        num_1 = 8'h01; num_2 = 8'h02;
        for (int k = 0; k < int'(W); k++) begin
            check("b2b busy1", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("b2b done1", 32'(done), 32'd1);
        check("b2b sum1", 32'(sum), 32'h30);
        check("b2b carry1", 32'(carry), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            check("b2b busy2", 32'(busy), 32'd1);
            check("b2b sum_held", 32'(sum), 32'h30);
            @(negedge clk);
        end
        check("b2b done2", 32'(done), 32'd1);
        check("b2b sum2", 32'(sum), 32'h03);
        @(negedge clk);
        prev_sum = 8'h03; prev_carry = 1'b0;

        do_op("55+0A glitch", 8'h55, 8'h0A, 1'b0, 1'b0, 2);
        check("glitch const", 32'(sum), 32'h5F);

        // Reset mid-RUN aborts and clears outputs immediately.
        start = 1'b1; num_1 = 8'h80; num_2 = 8'h80; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort sum", 32'(sum), 32'd0);
        check("abort carry", 32'(carry), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        prev_sum = '0; prev_carry = 1'b0;
        @(negedge clk);
        for (int k = 0; k < int'(W) + 2; k++) begin
            check("abort stays_idle", 32'({busy, done}), 32'd0);
            @(negedge clk);
        end
        do_op("80+80", 8'h80, 8'h80, 1'b0, 1'b0, -1);

`ifdef SERIAL_ADD_SUB_EN
        do_op("05-07", 8'h05, 8'h07, 1'b0, 1'b1, -1);
        check("05-07 const", 32'({carry, sum}), 32'h0FE);
        do_op("07-05", 8'h07, 8'h05, 1'b0, 1'b1, -1);
        check("07-05 const", 32'({carry, sum}), 32'h102);
`endif

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op("rand", ra, rb, rc, rs, (i % 3 == 0) ? int'($urandom_range(0, W - 1)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: one instance of the team's single-bit full adder cell is reused over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Trades area for latency in the simple ALU datapath; ALU control talks to it via a start/busy/done handshake.
- Block owns operand shift registers, the carry flip-flop, the bit counter and the sequencing FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on rising clk edge.
- num_1  input  WIDTH  operand A; captured only when start is accepted.
- num_2  input  WIDTH  operand B; captured only when start is accepted.
- c_in  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse marking the result as valid.
- sum  output  WIDTH  result; held stable between completions.
- carry  output  1  final carry-out; held stable between completions.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, sum=0, carry=0; shift registers, counter and carry flip-flop all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch num_1 and num_2 into shift registers a_sr/b_sr, load c_in into carry_ff, bit_cnt=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, edges E1..E(WIDTH):
  - Full adder inputs are a_sr[0], b_sr[0] and carry_ff.
  - Each edge: its sum bit shifts into the MSB of s_sr (s_sr shifts right); carry_ff takes its carry output; a_sr and b_sr shift right; bit_cnt increments.
  - At the edge where bit_cnt==WIDTH-1: copy the completed s_sr into sum, copy the new carry into carry, go to DONE.
- DONE, one cycle between E(WIDTH) and E(WIDTH+1):
  - done=1.
  - Next state is RUN if start=1 (back-to-back; new operands latched exactly as from IDLE), otherwise IDLE.
- Latency: done is high in the cycle following WIDTH RUN cycles. Start-to-done spacing is exactly WIDTH edges.
- busy=1 only in RUN; done=1 only in DONE. The two are never high together.
- start while in RUN: ignored; no effect on operands or sequence.
- sum and carry change only on entry to DONE (or on reset); no partial results are visible.
- Arithmetic: {carry,sum} = num_1 + num_2 + c_in, modulo 2^(WIDTH+1).
- Reset asserted mid-RUN: operation aborted, outputs cleared; no done pulse.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, b_sr is loaded with ~num_2 and carry_ff with 1 (c_in ignored), giving sum = num_1 - num_2 mod 2^WIDTH.
  - carry=1 means no borrow.
- Not defined: port sub does not exist; addition only.

Test Plan (WIDTH=8):
- Reset during idle, then release -> sum=0x00, carry=0, busy=0, done=0; start pulse with 0x35+0x4A, c_in=0 -> busy for 8 cycles, done 1 cycle, sum=0x7F, carry=0.
- 0xFF+0x01, c_in=0 -> sum=0x00, carry=1; 0xFF+0xFF, c_in=1 -> sum=0xFF, carry=1.
- Start held high continuously with 0x10+0x20 then 0x01+0x02 -> results 0x30 and 0x03; each done pulse is followed by busy=1 on the next cycle, with no IDLE gap.
- Start pulse with 0x55+0x0A; at RUN cycle 3, start pulse with operands changed to 0xFF/0xFF -> ignored, sum=0x5F after the original 8 cycles.
- Start 0x80+0x80, rst asserted mid-RUN at cycle 4 -> outputs 0 immediately, no done; next start 0x80+0x80 -> sum=0x00, carry=1.
- With SERIAL_ADD_SUB_EN, sub=1: 0x05-0x07 -> sum=0xFE, carry=0; 0x07-0x05 -> sum=0x02, carry=1.
